ping_pong_packer: RTL and testbench

- Write-side counterpart of the ping-pong unpacker: collects 10-bit items and packs them into 32-bit words.
- Packed word format: [1:0] item count, [11:2] item0, [21:12] item1, [31:22] item2.
- Two banks alternate: one fills from the item stream while the other is offered on the word interface.
- Sits upstream of the unpacker; both sides use valid/ready.

---
 rtl/ping_pong_pkg.sv | 35 +++
 rtl/pp_bank.sv | 56 +++++
 rtl/ping_pong_packer.sv | 125 ++++++++++++
 tb/tb_ping_pong_packer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pong_pkg.sv
// Shared types, field layout and word-packing helper for the ping-pong packer/unpacker pair.
package ping_pong_pkg;

  localparam int ITEM_W    = 10;
  localparam int CNT_W     = 2;
  localparam int WORD_W    = 32;
  localparam int MAX_ITEMS = 3;

  localparam int CNT_LSB   = 0;
  localparam int ITEM0_LSB = 2;
  localparam int ITEM1_LSB = 12;
  localparam int ITEM2_LSB = 22;

  typedef logic [ITEM_W-1:0]          item_t;
  typedef logic [CNT_W-1:0]           cnt_t;
  typedef logic [WORD_W-1:0]          word_t;
  typedef item_t [MAX_ITEMS-1:0]      items_t;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  // Slots at index >= count are forced to zero so stale items never leak into a word.
  function automatic word_t pack_word(input cnt_t count, input items_t items);
    word_t w;
    w = '0;
    w[CNT_LSB +: CNT_W] = count;
    if (count > 2'd0) w[ITEM0_LSB +: ITEM_W] = items[0];
    if (count > 2'd1) w[ITEM1_LSB +: ITEM_W] = items[1];
    if (count > 2'd2) w[ITEM2_LSB +: ITEM_W] = items[2];
    return w;
  endfunction

endpackage

// File: rtl/pp_bank.sv
// One packer bank: item slots, fill count and full flag with write/close/clear controls.
module pp_bank
  import ping_pong_pkg::*;
(
  input  logic   Clk,
  input  logic   Rst_n,
  input  logic   wr_en_i,
  input  item_t  item_i,
  input  logic   close_i,
  input  logic   clear_i,
  output items_t items_o,
  output cnt_t   count_o,
  output logic   full_o
);

  items_t items_q, items_d;
  cnt_t   count_q, count_d;
  logic   full_q,  full_d;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    items_d = items_q;
    count_d = count_q;
    full_d  = full_q;
    if (wr_en_i) begin
      for (int i = 0; i < MAX_ITEMS; i++) begin
        if (count_q == cnt_t'(i)) items_d[i] = item_i;
      end
      count_d = count_q + cnt_t'(1);
    end
    if (close_i) full_d = 1'b1;
    if (clear_i) begin
      full_d  = 1'b0;
      count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments; item slots are reset as well so a
  // discarded word leaves nothing behind.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      items_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      items_q <= items_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign items_o = items_q;
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/ping_pong_packer.sv
// Packs 10-bit items into 32-bit words through two alternating banks.
// Optional idle-timeout flush of partial words is enabled by defining PACK_TIMEOUT_EN.
module ping_pong_packer
  import ping_pong_pkg::*;
#(
  parameter int PACK_NUM       = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [ITEM_W-1:0] In_data,
  input  logic              In_last,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [WORD_W-1:0] Out_data
);

  if (PACK_NUM < 1 || PACK_NUM > MAX_ITEMS) begin : g_bad_pack_num
    $error("ping_pong_packer: PACK_NUM must be in 1..3");
  end

  items_t     bank_items [2];
  cnt_t       bank_count [2];
  logic [1:0] bank_full;
  logic [1:0] bank_wr_en;
  logic [1:0] bank_close;
  logic [1:0] bank_clear;
  logic [1:0] full_nxt;

  bank_e wr_bank_q, wr_bank_d;
  bank_e rd_bank_q, rd_bank_d;
  logic  in_ready_q, in_ready_d;

  cnt_t  wr_count;
  logic  accept;
  logic  drain;
  logic  last_slot;
  logic  close_wr;
  logic  timeout_close;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pp_bank u_bank (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .wr_en_i (bank_wr_en[b]),
      .item_i  (In_data),
      .close_i (bank_close[b]),
      .clear_i (bank_clear[b]),
      .items_o (bank_items[b]),
      .count_o (bank_count[b]),
      .full_o  (bank_full[b])
    );
  end

  assign wr_count  = bank_count[wr_bank_q];
  assign accept    = In_valid && in_ready_q;
  assign drain     = Out_valid && Out_ready;
  assign last_slot = ({1'b0, wr_count} + 3'd1) == 3'(PACK_NUM);
  assign close_wr  = (accept && (last_slot || In_last)) || timeout_close;

  always_comb begin
    bank_wr_en = '0;
    bank_close = '0;
    bank_clear = '0;
    bank_wr_en[wr_bank_q] = accept;
    bank_close[wr_bank_q] = close_wr;
    bank_clear[rd_bank_q] = drain;
    wr_bank_d = close_wr ? bank_e'(~wr_bank_q) : wr_bank_q;
    rd_bank_d = drain    ? bank_e'(~rd_bank_q) : rd_bank_q;
    // In_ready is registered from next-state bank flags, so Out_ready never reaches it combinationally.
    full_nxt   = (bank_full & ~bank_clear) | bank_close;
    in_ready_d = ~full_nxt[wr_bank_d];
  end

`ifdef PACK_TIMEOUT_EN
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("ping_pong_packer: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [7:0] idle_q, idle_d;
  logic       partial;

  assign partial = !bank_full[wr_bank_q] && (wr_count != '0);

  // The close fires on the edge that ends the TIMEOUT_CYCLES-th idle cycle; an accept always wins.
  always_comb begin
    idle_d        = idle_q;
    timeout_close = 1'b0;
    if (accept || !partial) begin
      idle_d = '0;
    end else if (idle_q == 8'(TIMEOUT_CYCLES - 1)) begin
      timeout_close = 1'b1;
      idle_d        = '0;
    end else begin
      idle_d = idle_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign timeout_close = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_bank_q  <= BANK0;
      rd_bank_q  <= BANK0;
      in_ready_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign In_ready  = in_ready_q;
  assign Out_valid = bank_full[rd_bank_q];
  assign Out_data  = Out_valid ? pack_word(bank_count[rd_bank_q], bank_items[rd_bank_q]) : '0;

endmodule

// File: tb/tb_ping_pong_packer.sv
// Self-checking bench for ping_pong_packer against a queue-based word model.
module tb_ping_pong_packer;

  localparam int PACK_NUM       = 3;
  localparam int TIMEOUT_CYCLES = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [9:0]  in_data   = '0;
  logic        in_last   = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int tests_run    = 0;
  int tests_failed = 0;

  int unsigned cur_items[$];
  logic [31:0] exp_q[$];

  ping_pong_packer #(
    .PACK_NUM       (PACK_NUM),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .In_valid  (in_valid),
    .In_ready  (in_ready),
    .In_data   (in_data),
    .In_last   (in_last),
    .Out_valid (out_valid),
    .Out_ready (out_ready),
    .Out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Word value from the format: count + 4 * (item0 + 1024*item1 + 1024^2*item2).
  task automatic model_accept(input logic [9:0] d, input logic l);
    int unsigned w;
    int unsigned mult;
    cur_items.push_back(int'(d));
    if (cur_items.size() == PACK_NUM || l) begin
      w    = cur_items.size();
      mult = 4;
      foreach (cur_items[i]) begin
        w    = w + cur_items[i] * mult;
        mult = mult * 1024;
      end
      exp_q.push_back(w);
      cur_items.delete();
    end
  endtask

  task automatic tick();
    logic acc;
    logic drn;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (acc) model_accept(in_data, in_last);
    if (drn && exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_in_ready_low: got %0b expected 0", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
    end
    tests_run++;
    if (out_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_out_data: got %h expected 00000000", out_data);
    end
    rst_n = 1'b1;
    cur_items.delete(); exp_q.delete();
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_release_in_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 10'(i + 1); in_last = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL basic_early_valid[%0d]: got %0b expected 0", i, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL basic_valid: got %0b expected 1", out_valid);
    end
    tests_run++;
    if (out_data !== 32'h00C02007) begin
      tests_failed++; $display("FAIL basic_data: got %h expected 00c02007", out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_drained: got %0b expected 0", out_valid);
    end
  endtask

  task automatic test_last();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 10'h3FF; in_last = 1'b0;
    tick();
    in_data = 10'h155; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL last_valid: got %0b expected 1", out_valid);
    end
    tests_run++;
    if (out_data !== 32'h00155FFE) begin
      tests_failed++; $display("FAIL last_data: got %h expected 00155ffe", out_data);
    end
    tick();
  endtask

  task automatic test_stall();
    logic exp_rdy;
    logic [31:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 10'($urandom_range(0, 1023)); in_last = 1'b0;
      exp_rdy = (exp_q.size() < 2);
      tests_run++;
      if (in_ready !== exp_rdy) begin
        tests_failed++; $display("FAIL stall_in_ready[%0d]: got %0b expected %0b", i, in_ready, exp_rdy);
      end
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL stall_both_full_ready: got %0b expected 0", in_ready);
    end
    held = exp_q.size() > 0 ? exp_q[0] : 32'h0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got valid=%0b data=%h expected valid=1 data=%h", k, out_valid, out_data, held);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL stall_ready_return: got %0b expected 1", in_ready);
    end
    held = exp_q.size() > 0 ? exp_q[0] : 32'h0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== held) begin
      tests_failed++;
      $display("FAIL stall_second_word: got valid=%0b data=%h expected valid=1 data=%h", out_valid, out_data, held);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stall_empty: got %0b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int          accepted = 0;
    int          cycles   = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        exp_vld;
    logic        exp_rdy;
    while (accepted < 300 && cycles < 4000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'b1;
      in_data   = 10'($urandom_range(0, 1023));
      in_last   = (accepted == 299) || ($urandom_range(0, 7) == 0);
      exp_vld   = (exp_q.size() > 0);
      exp_rdy   = (exp_q.size() < 2);
      tests_run++;
      if (out_valid !== exp_vld) begin
        tests_failed++; $display("FAIL rand_valid@%0d: got %0b expected %0b", cycles, out_valid, exp_vld);
      end
      tests_run++;
      if (in_ready !== exp_rdy) begin
        tests_failed++; $display("FAIL rand_ready@%0d: got %0b expected %0b", cycles, in_ready, exp_rdy);
      end
      if (out_valid && exp_vld) begin
        tests_run++;
        if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL rand_data@%0d: got %h expected %h", cycles, out_data, exp_q[0]);
        end
      end
      if (prev_stall) begin
        tests_run++;
        if (out_data !== prev_data || out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL rand_hold@%0d: got valid=%0b data=%h expected valid=1 data=%h", cycles, out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) accepted++;
      tick();
      cycles++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (accepted < 300) begin
      tests_failed++; $display("FAIL rand_budget: accepted %0d expected 300", accepted);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL rand_drain[%0d]: got valid=%0b data=%h expected valid=1 data=%h", k, out_valid, out_data, exp_q[0]);
      end
      tick();
    end
    tests_run++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_final_empty: got valid=%0b pending=%0d expected valid=0 pending=0", out_valid, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 10'($urandom_range(0, 1023)); in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_full_before: got %0b expected 1", out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_during: got ready=%0b valid=%0b expected ready=0 valid=0", in_ready, out_valid);
    end
    rst_n = 1'b1;
    cur_items.delete(); exp_q.delete();
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_after: got ready=%0b valid=%0b expected ready=1 valid=0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 10'($urandom_range(0, 1023)); in_last = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL rstmid_no_stale[%0d]: got %0b expected 0", i, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (exp_q.size() != 1 || out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL rstmid_fresh_word: got valid=%0b data=%h expected valid=1 data=%h",
               out_valid, out_data, exp_q.size() > 0 ? exp_q[0] : 32'h0);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 10'h0AA; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
`ifdef PACK_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL timeout_early[%0d]: got %0b expected 0", k, out_valid);
      end
      tick();
    end
    exp_q.push_back(32'(cur_items.size()) + 32'(cur_items[0]) * 32'd4);
    cur_items.delete();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h000002A9) begin
      tests_failed++;
      $display("FAIL timeout_word: got valid=%0b data=%h expected valid=1 data=000002a9", out_valid, out_data);
    end
`else
    for (int k = 0; k < 20; k++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL no_timeout_idle[%0d]: got %0b expected 0", k, out_valid);
      end
      tick();
    end
    in_valid = 1'b1; in_data = 10'h0BB; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (exp_q.size() != 1 || out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL no_timeout_word: got valid=%0b data=%h expected valid=1 data=%h",
               out_valid, out_data, exp_q.size() > 0 ? exp_q[0] : 32'h0);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_drained: got %0b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last();
    test_stall();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
